// File: rtl/channel_grant_if.sv
// Channel grant bus: requester-side request/release lines and controller-side grant outputs.
// master = requester front-end / test driver, slave = channel_grant_ctrl.
interface channel_grant_if;
   logic [7:0] req;
   logic       done;
   logic [3:0] grant;
   logic       grant_valid;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  grant,
      input  grant_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output grant,
      output grant_valid,
      output timeout
   );
endinterface

// File: rtl/channel_grant_ctrl.sv
// Shared-channel tenure controller: 8 requesters (7..5 fixed priority, 4..0 round-robin),
// one grant per session, tenure timeout, turnaround gap. Optional preemption: CHANNEL_PREEMPT_EN.
module channel_grant_ctrl #(
   parameter int unsigned MAX_TENURE  = 16,
   parameter int unsigned TURN_CYCLES = 1
) (
   input logic             clk,
   input logic             rst,
   channel_grant_if.slave  chan
);

   localparam int unsigned TW        = (MAX_TENURE > 0)  ? $clog2(MAX_TENURE + 1)  : 1;
   localparam int unsigned GW        = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
   localparam int unsigned CW        = (TW > GW) ? TW : GW;
   localparam int unsigned TURN_LAST = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      TURN
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      grant_q, grant_d;
   logic            valid_q, valid_d;
   logic            timeout_q, timeout_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      rr_last_q, rr_last_d;

   logic [2:0]      win_id;
   logic            win_hp;
   logic            rr_found;
   logic [3:0]      cand;
   logic            owner_drop;
   logic            tenure_hit;
   logic            preempt;
   logic            release_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
         rr_last_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
         rr_last_q <= rr_last_d;
      end
   end

   // Round-robin order: rr_last-1 down to 0, wrap to 4, rr_last itself last.
   always_comb begin
      win_id   = '0;
      win_hp   = 1'b0;
      rr_found = 1'b0;
      cand     = '0;
      if (chan.req[7]) begin
         win_id = 3'd7;
         win_hp = 1'b1;
      end else if (chan.req[6]) begin
         win_id = 3'd6;
         win_hp = 1'b1;
      end else if (chan.req[5]) begin
         win_id = 3'd5;
         win_hp = 1'b1;
      end else begin
         for (int unsigned i = 1; i <= 5; i++) begin
            cand = 4'(rr_last_q) + 4'd5 - 4'(i);
            if (cand >= 4'd5) cand = cand - 4'd5;
            if (!rr_found && chan.req[cand[2:0]]) begin
               win_id   = cand[2:0];
               rr_found = 1'b1;
            end
         end
      end
   end

`ifdef CHANNEL_PREEMPT_EN
   assign preempt = (grant_q <= 3'd4) && (chan.req[7:5] != '0);
`else
   assign preempt = 1'b0;
`endif

   assign owner_drop  = !chan.req[grant_q];
   assign tenure_hit  = (MAX_TENURE != 0) && (cnt_q == CW'(MAX_TENURE));
   assign release_req = chan.done || owner_drop || preempt;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      rr_last_d = rr_last_q;
      case (state_q)
         IDLE: begin
            if (chan.req != '0) begin
               grant_d = win_id;
               valid_d = 1'b1;
               cnt_d   = CW'(1);
               state_d = HOLD;
               if (!win_hp) rr_last_d = win_id;
            end
         end
         HOLD: begin
            // Any explicit release outranks the tenure limit, so timeout only fires alone.
            if (release_req || tenure_hit) begin
               valid_d   = 1'b0;
               cnt_d     = '0;
               timeout_d = !release_req;
               state_d   = (TURN_CYCLES == 0) ? IDLE : TURN;
            end else if (MAX_TENURE != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TURN: begin
            if (cnt_q == CW'(TURN_LAST)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   assign chan.grant       = {1'b0, grant_q};
   assign chan.grant_valid = valid_q;
   assign chan.timeout     = timeout_q;

   a_timeout_ends_session: assert property (@(posedge clk) disable iff (rst)
      timeout_q |-> !valid_q);

endmodule

// File: tb/tb_channel_grant_ctrl.sv
// Self-checking bench for channel_grant_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a session-level reference model.
module tb_channel_grant_ctrl;

   localparam int MAX_T  = 16;
   localparam int TURN_C = 1;

   logic clk;
   logic rst;
   channel_grant_if bus();

   channel_grant_ctrl #(
      .MAX_TENURE  (MAX_T),
      .TURN_CYCLES (TURN_C)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .chan (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: session view (owner, cycles owned, dead cycles remaining).
   int m_grant   = 0;
   bit m_valid   = 1'b0;
   bit m_timeout = 1'b0;
   int m_tenure  = 0;
   int m_gap     = 0;
   int m_rr      = 0;
   bit m_live    = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [7:0] r, input int rr);
      for (int id = 7; id >= 5; id--) if (r[id]) return id;
      for (int id = 4; id >= 0; id--) if (id < rr && r[id]) return id;
      for (int id = 4; id >= 0; id--) if (id >= rr && r[id]) return id;
      return 0;
   endfunction

   task automatic model_step();
      bit rel;
      if (rst) begin
         m_grant = 0; m_valid = 1'b0; m_timeout = 1'b0;
         m_tenure = 0; m_gap = 0; m_rr = 0; m_live = 1'b1;
      end else if (m_live) begin
         m_timeout = 1'b0;
         if (m_valid) begin
            rel = bus.done || !bus.req[m_grant];
`ifdef CHANNEL_PREEMPT_EN
            if (m_grant < 5 && bus.req[7:5] != 3'b000) rel = 1'b1;
`endif
            if (rel || (MAX_T != 0 && m_tenure == MAX_T)) begin
               m_valid   = 1'b0;
               m_timeout = !rel;
               m_gap     = TURN_C;
            end else begin
               m_tenure++;
            end
         end else if (m_gap != 0) begin
            m_gap--;
         end else if (bus.req != 8'h00) begin
            m_grant  = pick(bus.req, m_rr);
            m_valid  = 1'b1;
            m_tenure = 1;
            if (m_grant < 5) m_rr = m_grant;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            chk("model_grant", int'(bus.grant), m_grant);
            chk("model_valid", int'(bus.grant_valid), int'(m_valid));
            chk("model_timeout", int'(bus.timeout), int'(m_timeout));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!bus.grant_valid && n < 20) begin
         step();
         n++;
      end
      n_checks++;
      if (!bus.grant_valid) begin
         n_errors++;
         $display("FAIL %s: grant_valid still %0d after %0d cycles, required 1", tag, bus.grant_valid, n);
      end
   endtask

   task automatic release_and_drain();
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      bus.req  = 8'h00;
      repeat (TURN_C + 1) step();
   endtask

   int         count;
   int         exp_seq [7] = '{4, 3, 6, 2, 1, 0, 4};
   logic [7:0] req_seq [7] = '{8'h1F, 8'h1F, 8'h5F, 8'h1F, 8'h1F, 8'h1F, 8'h1F};
   logic [7:0] r;

   initial begin
      rst = 1'b1;
      bus.req  = 8'h00;
      bus.done = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("reset_grant", int'(bus.grant), 0);
      chk("reset_valid", int'(bus.grant_valid), 0);
      chk("reset_timeout", int'(bus.timeout), 0);

      // Single requester, one-cycle latency, done release
      bus.req = 8'h01;
      step();
      chk("req0_valid", int'(bus.grant_valid), 1);
      chk("req0_grant", int'(bus.grant), 0);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("done_release_valid", int'(bus.grant_valid), 0);
      bus.req = 8'h00;
      repeat (TURN_C + 1) step();

      // Fixed priority, owner drop, turnaround gap
      bus.req = 8'hA0;
      step();
      chk("hp_grant7", int'(bus.grant), 7);
      chk("hp_valid7", int'(bus.grant_valid), 1);
      bus.req = 8'h20;
      step();
      chk("drop_valid_low", int'(bus.grant_valid), 0);
      step();
      chk("gap_valid_low", int'(bus.grant_valid), 0);
      step();
      chk("gap_then_grant5", int'(bus.grant), 5);
      chk("gap_then_valid", int'(bus.grant_valid), 1);
      release_and_drain();

      // Round-robin sequence with an interleaved high-priority session
      for (int i = 0; i < 7; i++) begin
         bus.req = req_seq[i];
         wait_valid("rr_wait");
         chk("rr_grant", int'(bus.grant), exp_seq[i]);
         bus.done = 1'b1;
         step();
         bus.done = 1'b0;
      end
      bus.req = 8'h00;
      repeat (TURN_C + 1) step();

      // Tenure timeout, then re-grant, then done on the last allowed cycle
      bus.req = 8'h04;
      wait_valid("tmo_wait");
      chk("tmo_grant", int'(bus.grant), 2);
      count = 0;
      while (bus.grant_valid && count < 40) begin
         chk("tmo_no_early_pulse", int'(bus.timeout), 0);
         count++;
         step();
      end
      chk("tmo_valid_cycles", count, MAX_T);
      chk("tmo_pulse", int'(bus.timeout), 1);
      chk("tmo_pulse_valid", int'(bus.grant_valid), 0);
      step();
      chk("tmo_pulse_single", int'(bus.timeout), 0);
      wait_valid("tmo_regrant_wait");
      chk("tmo_regrant", int'(bus.grant), 2);
      repeat (MAX_T - 1) step();
      chk("last_cycle_valid", int'(bus.grant_valid), 1);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk("done_beats_tmo", int'(bus.timeout), 0);
      chk("done_beats_tmo_valid", int'(bus.grant_valid), 0);
      bus.req = 8'h00;
      repeat (TURN_C + 1) step();

      // Reset during a session
      bus.req = 8'h08;
      wait_valid("rst_wait");
      chk("rst_pre_grant", int'(bus.grant), 3);
      rst = 1'b1;
      step();
      chk("rst_mid_grant", int'(bus.grant), 0);
      chk("rst_mid_valid", int'(bus.grant_valid), 0);
      chk("rst_mid_timeout", int'(bus.timeout), 0);
      rst = 1'b0;
      bus.req = 8'h1F;
      wait_valid("rst_rr_wait");
      chk("rst_rr_restart", int'(bus.grant), 4);
      release_and_drain();

      // High-priority request arriving during a low-priority session
      bus.req = 8'h08;
      wait_valid("pre_wait");
      chk("pre_owner", int'(bus.grant), 3);
      bus.req = 8'h48;
`ifdef CHANNEL_PREEMPT_EN
      step();
      chk("pre_forced_low", int'(bus.grant_valid), 0);
      chk("pre_no_timeout", int'(bus.timeout), 0);
`else
      repeat (3) begin
         step();
         chk("nopre_still_valid", int'(bus.grant_valid), 1);
         chk("nopre_still_owner", int'(bus.grant), 3);
      end
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
`endif
      wait_valid("pre_hp_wait");
      chk("pre_hp_grant", int'(bus.grant), 6);
      release_and_drain();

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(39) == 0) begin
            r = 8'($urandom);
            if ($urandom_range(3) != 0) r[7:5] = 3'b000;
            bus.req = r;
         end
         bus.done = ($urandom_range(24) == 0);
         rst = ($urandom_range(599) == 0);
         step();
      end
      rst = 1'b0;
      bus.done = 1'b0;
      bus.req = 8'h00;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
